// File: rtl/mat_row_argmax_if.sv
// Purpose: bundles the score-matrix input and the argmax result output of mat_row_argmax.
// Latency: none; this is wiring only.
// Backpressure: input_mat_stb/input_mat_ack and output_stb/output_ack word handshakes.
interface mat_row_argmax_if #(
    parameter int M     = 1,
    parameter int P     = 1,
    parameter int IDX_W = (P > 1) ? $clog2(P) : 1
);
    logic [M-1:0][P-1:0][31:0] input_mat;
    logic                      input_mat_stb;
    logic                      input_mat_ack;
    logic [M-1:0][IDX_W-1:0]   output_idx;
    logic [M-1:0][31:0]        output_max;
    logic                      output_stb;
    logic                      output_ack;

    // Block side: consumes matrices, produces results.
    modport slave (
        input  input_mat, input_mat_stb, output_ack,
        output input_mat_ack, output_idx, output_max, output_stb
    );

    // Environment side: supplies matrices, consumes results.
    modport master (
        output input_mat, input_mat_stb, output_ack,
        input  input_mat_ack, output_idx, output_max, output_stb
    );
endinterface

// File: rtl/mat_row_argmax.sv
// Purpose: per-row argmax over an M x P float32 matrix, one column per cycle, all rows in parallel.
// Latency: output_stb rises P+1 cycles after the input transfer cycle; one matrix per P+2 cycles at best.
// Backpressure: input_mat_ack held low from accept until the result is taken; results held while output_ack is low.
module mat_row_argmax #(
    parameter int M     = 1,
    parameter int P     = 1,
    parameter int IDX_W = (P > 1) ? $clog2(P) : 1
) (
    input  logic            clk,
    input  logic            rst,
    mat_row_argmax_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(P - 1);

    typedef enum logic [1:0] {GET_MAT, SCAN, PUT} state_t;

    state_t                    state_q, state_d;
    logic                      ack_q, ack_d;
    logic                      stb_q, stb_d;
    logic [IDX_W-1:0]          col_q, col_d;
    logic [M-1:0][P-1:0][31:0] mat_q, mat_d;
    logic [M-1:0][31:0]        cur_max_q, cur_max_d;
    logic [M-1:0][IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [M-1:0][31:0]        out_max_q, out_max_d;
    logic [M-1:0][IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [M-1:0][31:0]        step_max;
    logic [M-1:0][IDX_W-1:0]   step_idx;

    // Float "a > b" using sign/magnitude ordering; NaN never wins, but any number beats a held NaN.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan)                                    gt = 1'b0;
        else if (b_nan)                               gt = 1'b1;
        else if (a[30:0] == 31'd0 && b[30:0] == 31'd0) gt = 1'b0;
        else if (a[31] != b[31])                      gt = ~a[31];
        else if (!a[31])                              gt = a[30:0] > b[30:0];
        else                                          gt = a[30:0] < b[30:0];
    endfunction

    // Running max/index after folding in the current column; column 0 seeds unconditionally.
    always_comb begin
        step_max = cur_max_q;
        step_idx = cur_idx_q;
        for (int r = 0; r < M; r++) begin
            if (col_q == '0 || gt(mat_q[r][col_q], cur_max_q[r])) begin
                step_max[r] = mat_q[r][col_q];
                step_idx[r] = col_q;
            end
        end
    end

    // Next-state and datapath updates for the accept / scan / present sequence.
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        stb_d     = stb_q;
        col_d     = col_q;
        mat_d     = mat_q;
        cur_max_d = cur_max_q;
        cur_idx_d = cur_idx_q;
        out_max_d = out_max_q;
        out_idx_d = out_idx_q;
        case (state_q)
            GET_MAT: begin
                ack_d = 1'b1;
                if (ack_q && bus.input_mat_stb) begin
                    ack_d   = 1'b0;
                    mat_d   = bus.input_mat;
                    col_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                cur_max_d = step_max;
                cur_idx_d = step_idx;
                if (col_q == LAST_COL) begin
                    // Last column's comparison lands directly in the output registers.
                    out_max_d = step_max;
                    out_idx_d = step_idx;
                    stb_d     = 1'b1;
                    state_d   = PUT;
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end
            PUT: begin
                if (stb_q && bus.output_ack) begin
                    // Re-open the input immediately so a new matrix can land next cycle.
                    stb_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = GET_MAT;
                end
            end
            default: state_d = GET_MAT;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET_MAT;
            ack_q     <= 1'b0;
            stb_q     <= 1'b0;
            col_q     <= '0;
            mat_q     <= '0;
            cur_max_q <= '0;
            cur_idx_q <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            stb_q     <= stb_d;
            col_q     <= col_d;
            mat_q     <= mat_d;
            cur_max_q <= cur_max_d;
            cur_idx_q <= cur_idx_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign bus.input_mat_ack = ack_q;
    assign bus.output_stb    = stb_q;
    assign bus.output_idx    = out_idx_q;
    assign bus.output_max    = out_max_q;
endmodule

// File: tb/tb_mat_row_argmax.sv
// Purpose: self-checking bench for mat_row_argmax with M=2, P=4.
// Latency: checks output_stb arrives P cycles after the transfer edge.
// Backpressure: exercises held output_ack, back-to-back flow and reset mid-scan.
module tb_mat_row_argmax;
    localparam int M     = 2;
    localparam int P     = 4;
    localparam int IDX_W = 2;

    typedef logic [P-1:0][31:0]        row_t;
    typedef logic [M-1:0][P-1:0][31:0] mat_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mat_row_argmax_if #(.M(M), .P(P), .IDX_W(IDX_W)) bus ();

    mat_row_argmax #(.M(M), .P(P), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit is_nan(input logic [31:0] a);
        return (a[30:23] == 8'hFF) && (a[22:0] != 0);
    endfunction

    // Total order on non-NaN floats: signed magnitude as a plain integer, both zeros map to 0.
    function automatic longint fkey(input logic [31:0] a);
        longint mag;
        mag = longint'({1'b0, a[30:0]});
        return a[31] ? -mag : mag;
    endfunction

    function automatic void ref_row(input row_t row, output int idx, output logic [31:0] mx);
        int best;
        best = 0;
        for (int c = 1; c < P; c++) begin
            if (!is_nan(row[c]) && (is_nan(row[best]) || fkey(row[c]) > fkey(row[best])))
                best = c;
        end
        idx = best;
        mx  = row[best];
    endfunction

    function automatic row_t mk_row(input logic [31:0] e0, e1, e2, e3);
        row_t r;
        r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
        return r;
    endfunction

    function automatic logic [31:0] rand_elem(input logic [31:0] prev);
        logic [31:0] sp [7];
        sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
        sp[3] = 32'hFF800000; sp[4] = 32'h7FC00000; sp[5] = 32'h7F800001;
        sp[6] = 32'hFFC00000;
        case ($urandom_range(0, 6))
            0, 1:    return $urandom();
            2:       return sp[$urandom_range(0, 6)];
            3, 4:    return {1'($urandom_range(0, 1)), 8'(125 + $urandom_range(0, 4)),
                             2'($urandom_range(0, 3)), 21'd0};
            default: return prev;
        endcase
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < M; r++) begin
            m[r][0] = rand_elem(32'h3F800000);
            for (int c = 1; c < P; c++) m[r][c] = rand_elem(m[r][c-1]);
        end
        return m;
    endfunction

    // ---------------- handshake helpers (no checking of results) ----------------
    task automatic send_mat(input mat_t m);
        int ok;
        ok = 0;
        bus.input_mat     = m;
        bus.input_mat_stb = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.input_mat_ack) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.input_mat_stb = 1'b0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL send_timeout: input_mat_ack=%0b, required a transfer within 50 cycles", bus.input_mat_ack);
        end
    endtask

    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.output_stb) begin
                cyc = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic take_out();
        bus.output_ack = 1'b1;
        @(posedge clk); #1;
        bus.output_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.input_mat_stb = 1'b0;
        bus.output_ack    = 1'b0;
        bus.input_mat     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (bus.input_mat_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", bus.input_mat_ack); end
        if (bus.output_stb !== 1'b0)    begin errors++; $display("FAIL reset_stb: got %0b want 0", bus.output_stb); end
        if (bus.output_idx !== '0)      begin errors++; $display("FAIL reset_idx: got %h want 0", bus.output_idx); end
        if (bus.output_max !== '0)      begin errors++; $display("FAIL reset_max: got %h want 0", bus.output_max); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.input_mat_ack !== 1'b1) begin errors++; $display("FAIL reset_ack_rise: got %0b want 1", bus.input_mat_ack); end
    endtask

    task automatic test_basic();
        mat_t m;
        int   cyc;
        m[0] = mk_row(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000);
        m[1] = mk_row(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hC0800000);
        send_mat(m);
        wait_out(cyc);
        checks += 5;
        if (cyc != P) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, P); end
        if (bus.output_idx[0] !== 2'd1) begin errors++; $display("FAIL basic_idx0: got %0d want 1", bus.output_idx[0]); end
        if (bus.output_idx[1] !== 2'd1) begin errors++; $display("FAIL basic_idx1: got %0d want 1", bus.output_idx[1]); end
        if (bus.output_max[0] !== 32'h40000000) begin errors++; $display("FAIL basic_max0: got %h want 40000000", bus.output_max[0]); end
        if (bus.output_max[1] !== 32'hBF800000) begin errors++; $display("FAIL basic_max1: got %h want bf800000", bus.output_max[1]); end
        take_out();
    endtask

    task automatic test_tie_zero();
        mat_t m;
        int   cyc;
        m[0] = mk_row(32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800000);
        m[1] = mk_row(32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000);
        send_mat(m);
        wait_out(cyc);
        checks += 4;
        if (bus.output_idx[0] !== 2'd2) begin errors++; $display("FAIL tie_idx: got %0d want 2", bus.output_idx[0]); end
        if (bus.output_max[0] !== 32'h3F800000) begin errors++; $display("FAIL tie_max: got %h want 3f800000", bus.output_max[0]); end
        if (bus.output_idx[1] !== 2'd0) begin errors++; $display("FAIL zero_idx: got %0d want 0", bus.output_idx[1]); end
        if (bus.output_max[1] !== 32'h80000000) begin errors++; $display("FAIL zero_max: got %h want 80000000", bus.output_max[1]); end
        take_out();
    endtask

    task automatic test_nan_inf();
        mat_t m;
        int   cyc;
        m[0] = mk_row(32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000);
        m[1] = mk_row(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000);
        send_mat(m);
        wait_out(cyc);
        checks += 4;
        if (bus.output_idx[0] !== 2'd2) begin errors++; $display("FAIL naninf_idx: got %0d want 2", bus.output_idx[0]); end
        if (bus.output_max[0] !== 32'h7F800000) begin errors++; $display("FAIL naninf_max: got %h want 7f800000", bus.output_max[0]); end
        if (bus.output_idx[1] !== 2'd0) begin errors++; $display("FAIL allnan_idx: got %0d want 0", bus.output_idx[1]); end
        if (bus.output_max[1] !== 32'h7FC00000) begin errors++; $display("FAIL allnan_max: got %h want 7fc00000", bus.output_max[1]); end
        take_out();
    endtask

    task automatic test_random();
        mat_t        m;
        int          cyc;
        int          eidx;
        logic [31:0] emax;
        for (int n = 0; n < 30; n++) begin
            m = rand_mat();
            send_mat(m);
            wait_out(cyc);
            checks++;
            if (cyc != P) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, cyc, P); end
            for (int r = 0; r < M; r++) begin
                ref_row(m[r], eidx, emax);
                checks += 2;
                if (bus.output_idx[r] !== IDX_W'(eidx)) begin
                    errors++; $display("FAIL rand_idx[%0d][%0d]: got %0d want %0d row=%h", n, r, bus.output_idx[r], eidx, m[r]);
                end
                if (bus.output_max[r] !== emax) begin
                    errors++; $display("FAIL rand_max[%0d][%0d]: got %h want %h row=%h", n, r, bus.output_max[r], emax, m[r]);
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            take_out();
        end
    endtask

    task automatic test_backpressure();
        mat_t        m;
        int          cyc;
        int          eidx [M];
        logic [31:0] emax [M];
        m = rand_mat();
        for (int r = 0; r < M; r++) ref_row(m[r], eidx[r], emax[r]);
        send_mat(m);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            checks += 2;
            if (bus.output_stb !== 1'b1) begin errors++; $display("FAIL bp_stb[%0d]: got %0b want 1", i, bus.output_stb); end
            if (bus.input_mat_ack !== 1'b0) begin errors++; $display("FAIL bp_inack[%0d]: got %0b want 0", i, bus.input_mat_ack); end
            for (int r = 0; r < M; r++) begin
                checks += 2;
                if (bus.output_idx[r] !== IDX_W'(eidx[r])) begin errors++; $display("FAIL bp_idx[%0d][%0d]: got %0d want %0d", i, r, bus.output_idx[r], eidx[r]); end
                if (bus.output_max[r] !== emax[r]) begin errors++; $display("FAIL bp_max[%0d][%0d]: got %h want %h", i, r, bus.output_max[r], emax[r]); end
            end
            @(posedge clk); #1;
        end
        take_out();
        checks += 2;
        if (bus.output_stb !== 1'b0) begin errors++; $display("FAIL bp_stb_drop: got %0b want 0", bus.output_stb); end
        if (bus.input_mat_ack !== 1'b1) begin errors++; $display("FAIL bp_inack_rise: got %0b want 1", bus.input_mat_ack); end
    endtask

    task automatic test_back_to_back();
        mat_t        mats [2];
        int          n_in, n_out, first, last;
        int          eidx;
        logic [31:0] emax;
        mats[0] = rand_mat();
        mats[1] = rand_mat();
        n_in = 0; n_out = 0; first = -1; last = -1;
        bus.output_ack = 1'b1;
        for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
            if (n_in < 2) begin
                bus.input_mat_stb = 1'b1;
                bus.input_mat     = mats[n_in];
            end else begin
                bus.input_mat_stb = 1'b0;
            end
            if (bus.output_stb) begin
                for (int r = 0; r < M; r++) begin
                    ref_row(mats[n_out][r], eidx, emax);
                    checks += 2;
                    if (bus.output_idx[r] !== IDX_W'(eidx)) begin errors++; $display("FAIL b2b_idx[%0d][%0d]: got %0d want %0d", n_out, r, bus.output_idx[r], eidx); end
                    if (bus.output_max[r] !== emax) begin errors++; $display("FAIL b2b_max[%0d][%0d]: got %h want %h", n_out, r, bus.output_max[r], emax); end
                end
                n_out++;
                last = cyc;
            end
            if (bus.input_mat_stb && bus.input_mat_ack) begin
                if (first < 0) first = cyc;
                n_in++;
            end
            @(posedge clk); #1;
        end
        bus.input_mat_stb = 1'b0;
        bus.output_ack    = 1'b0;
        checks += 2;
        if (n_out != 2) begin errors++; $display("FAIL b2b_count: got %0d results want 2", n_out); end
        if (last - first + 1 != 2 * (P + 2)) begin
            errors++; $display("FAIL b2b_cycles: got %0d want %0d", last - first + 1, 2 * (P + 2));
        end
        // No duplicate result after both were taken.
        repeat (3) begin
            checks++;
            if (bus.output_stb !== 1'b0) begin errors++; $display("FAIL b2b_extra_stb: got %0b want 0", bus.output_stb); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midscan();
        mat_t        m;
        int          cyc;
        int          eidx;
        logic [31:0] emax;
        m = rand_mat();
        send_mat(m);                      // now in first SCAN cycle (col 0)
        repeat (2) begin @(posedge clk); #1; end   // now in the col 2 cycle
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks += 4;
        if (bus.output_stb !== 1'b0) begin errors++; $display("FAIL midrst_stb: got %0b want 0", bus.output_stb); end
        if (bus.output_idx !== '0)   begin errors++; $display("FAIL midrst_idx: got %h want 0", bus.output_idx); end
        if (bus.output_max !== '0)   begin errors++; $display("FAIL midrst_max: got %h want 0", bus.output_max); end
        if (bus.input_mat_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack0: got %0b want 0", bus.input_mat_ack); end
        @(posedge clk); #1;
        checks += 2;
        if (bus.input_mat_ack !== 1'b1) begin errors++; $display("FAIL midrst_ack1: got %0b want 1", bus.input_mat_ack); end
        if (bus.output_stb !== 1'b0)    begin errors++; $display("FAIL midrst_nostb: got %0b want 0", bus.output_stb); end
        m = rand_mat();
        send_mat(m);
        wait_out(cyc);
        checks++;
        if (cyc != P) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", cyc, P); end
        for (int r = 0; r < M; r++) begin
            ref_row(m[r], eidx, emax);
            checks += 2;
            if (bus.output_idx[r] !== IDX_W'(eidx)) begin errors++; $display("FAIL midrst_idx[%0d]: got %0d want %0d", r, bus.output_idx[r], eidx); end
            if (bus.output_max[r] !== emax) begin errors++; $display("FAIL midrst_max[%0d]: got %h want %h", r, bus.output_max[r], emax); end
        end
        take_out();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_tie_zero();
        test_nan_inf();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
